// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing for the register scoreboard: regfile geometry and the
// width of the per-register outstanding-write counters.
package reg_scoreboard_pkg;
  localparam int REG_ADDR_SIZE = 4;
  localparam int REG_SIZE      = 32;
  localparam int SB_CNT_SIZE   = 2;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = REG_ADDR_SIZE + 1;
  localparam int CNT_W    = SB_CNT_SIZE;
endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register outstanding-write counter. Simultaneous inc and dec leave the
// count unchanged, and a dec at zero is ignored.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full
);
  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc && !dec)
      count <= count + 1'b1;
    else if (dec && !inc && count != '0)
      count <= count - 1'b1;
  end

  assign nonzero = (count != '0);
  assign full    = (count == {CNT_W{1'b1}});
endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side RAW/saturation hazard controller for the 2R/1W regfile.
// A same-cycle writeback is bypassed into the hazard check.
import reg_scoreboard_pkg::*;

module reg_scoreboard #(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_scoreboard_pkg::ADDR_W,
  parameter int CNT_W    = reg_scoreboard_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_wr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic                hazard_rs1,
  output logic                hazard_rs2,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wb_underflow
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            nonzero;
  logic [NUM_REGS-1:0]            full;
  logic                           fire;
  logic                           sat;
  logic [CNT_W-1:0]               eff_rs1, eff_rs2, eff_rd;

  // x0 is never tracked
  assign cnt[0]     = '0;
  assign nonzero[0] = 1'b0;
  assign full[0]    = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = fire && issue_wr && (issue_rd == ADDR_W'(r));
    assign dec = wb_valid && (wb_addr == ADDR_W'(r)) && nonzero[r];

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (flush),
      .inc     (inc),
      .dec     (dec),
      .count   (cnt[r]),
      .nonzero (nonzero[r]),
      .full    (full[r])
    );
  end

  // Effective count: registered count minus a retiring writeback this cycle
  always_comb begin
    eff_rs1 = cnt[issue_rs1];
    eff_rs2 = cnt[issue_rs2];
    eff_rd  = cnt[issue_rd];
    if (wb_valid && wb_addr == issue_rs1 && nonzero[issue_rs1]) eff_rs1 = eff_rs1 - 1'b1;
    if (wb_valid && wb_addr == issue_rs2 && nonzero[issue_rs2]) eff_rs2 = eff_rs2 - 1'b1;
    if (wb_valid && wb_addr == issue_rd  && nonzero[issue_rd])  eff_rd  = eff_rd  - 1'b1;
  end

  assign hazard_rs1  = issue_use_rs1 && (issue_rs1 != '0) && (eff_rs1 != '0);
  assign hazard_rs2  = issue_use_rs2 && (issue_rs2 != '0) && (eff_rs2 != '0);
  assign sat         = issue_wr && (issue_rd != '0) && (eff_rd == {CNT_W{1'b1}});
  assign issue_ready = !hazard_rs1 && !hazard_rs2 && !sat && !flush && !reset;
  assign fire        = issue_valid && issue_ready;
  assign busy_vec    = nonzero;

  // Sticky; flush keeps it so a kill cannot hide a retirement bug
  always_ff @(posedge clk) begin
    if (reset)
      wb_underflow <= 1'b0;
    else if (!flush && wb_valid && wb_addr != '0 && !nonzero[wb_addr])
      wb_underflow <= 1'b1;
  end

  logic unused;
  assign unused = ^full;
endmodule
